// File: rtl/burst_sequencer.sv
// Serialises one MRAM command per 23-cycle frame and captures serial read data into a response.
// Optional rsp_overrun sticky flag is built when BURST_SEQ_OVERRUN_EN is defined.
module burst_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_bytes,
    input  logic [19:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic [2:0]  rw_sel,
    output logic        addr_ser,
    output logic        data_ser,
    output logic        frame_start,
    input  logic        rd_ser_in,
    input  logic        rd_ser_valid,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    input  logic        rsp_ready,
    output logic        busy
`ifdef BURST_SEQ_OVERRUN_EN
    ,
    output logic        rsp_overrun
`endif
);

    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [4:0] LAST = 5'd22;

    state_t      state;
    logic [4:0]  cnt;
    logic [19:0] addr_sh;
    logic [15:0] data_sh;
    logic        armed;
    logic        cap_full;
    logic [4:0]  bit_cnt;
    logic [14:0] cap_sh;
    logic [15:0] cap_next;
    logic        blocked;
    logic        accept;
    logic        cap_done;

    // Only sized reads wait on an outstanding capture/response; writes and nops pass.
    assign blocked   = (armed || rsp_valid) && !cmd_op && (cmd_bytes != 2'b00);
    assign cmd_ready = rst && !blocked && ((state == IDLE) || (cnt == LAST));
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == RUN);
    assign cap_next  = {cap_sh, rd_ser_in};
    assign cap_done  = armed && rd_ser_valid && ((bit_cnt + 5'd1) == (cap_full ? 5'd16 : 5'd8));

    // Shift registers present bit k on the cycle the counter reads k; they drain to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            rw_sel      <= '0;
            addr_ser    <= 1'b0;
            data_ser    <= 1'b0;
            frame_start <= 1'b0;
        end else if (accept) begin
            state       <= RUN;
            cnt         <= '0;
            rw_sel      <= {cmd_bytes, cmd_op};
            frame_start <= 1'b1;
            addr_ser    <= 1'b0;
            data_ser    <= 1'b0;
            addr_sh     <= cmd_addr;
            data_sh     <= cmd_op ? cmd_wdata : '0;
        end else if (state == RUN) begin
            frame_start <= 1'b0;
            if (cnt == LAST) begin
                state    <= IDLE;
                cnt      <= '0;
                rw_sel   <= '0;
                addr_ser <= 1'b0;
                data_ser <= 1'b0;
            end else begin
                cnt      <= cnt + 5'd1;
                addr_ser <= addr_sh[19];
                data_ser <= data_sh[15];
                addr_sh  <= {addr_sh[18:0], 1'b0};
                data_sh  <= {data_sh[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed     <= 1'b0;
            cap_full  <= 1'b0;
            bit_cnt   <= '0;
            cap_sh    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            if (cap_done) begin
                rsp_valid <= 1'b1;
                rsp_data  <= cap_full ? cap_next : {8'h00, cap_next[7:0]};
                armed     <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                if (rsp_valid && rsp_ready)
                    rsp_valid <= 1'b0;
                if (armed && rd_ser_valid) begin
                    cap_sh  <= cap_next[14:0];
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (accept && !cmd_op && (cmd_bytes != 2'b00)) begin
                armed    <= 1'b1;
                bit_cnt  <= '0;
                cap_sh   <= '0;
                cap_full <= (cmd_bytes == 2'b11);
            end
        end
    end

`ifdef BURST_SEQ_OVERRUN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rsp_overrun <= 1'b0;
        else if (cap_done && rsp_valid && !rsp_ready)
            rsp_overrun <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_burst_sequencer.sv
// Bench for burst_sequencer: frame-level reference model compared every cycle, plus literal vectors.
module tb_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [1:0]  cmd_bytes = 2'b00;
    logic [19:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [2:0]  rw_sel;
    logic        addr_ser;
    logic        data_ser;
    logic        frame_start;
    logic        rd_ser_in = 1'b0;
    logic        rd_ser_valid = 1'b0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_ready = 1'b0;
    logic        busy;
`ifdef BURST_SEQ_OVERRUN_EN
    logic        rsp_overrun;
`endif

    int checks = 0;
    int errors = 0;

    burst_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_bytes(cmd_bytes), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rw_sel(rw_sel), .addr_ser(addr_ser), .data_ser(data_ser),
        .frame_start(frame_start), .rd_ser_in(rd_ser_in), .rd_ser_valid(rd_ser_valid),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy)
`ifdef BURST_SEQ_OVERRUN_EN
        , .rsp_overrun(rsp_overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame position plus latched command, and a bit list for captures.
    bit        m_frame;
    int        m_pos;
    bit        m_op;
    bit [1:0]  m_bytes;
    bit [19:0] m_addr;
    bit [15:0] m_wdata;
    bit        m_armed;
    bit        m_full;
    int        m_nb;
    bit [15:0] m_val;
    bit        m_rv;
    bit [15:0] m_rd;
    bit        m_ovr;

    function automatic bit m_ready();
        if (!rst) return 1'b0;
        if (m_frame && m_pos != 22) return 1'b0;
        if ((m_armed || m_rv) && !cmd_op && cmd_bytes != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_frame = 0; m_pos = 0; m_op = 0; m_bytes = 0; m_addr = 0; m_wdata = 0;
            m_armed = 0; m_full = 0; m_nb = 0; m_val = 0; m_rv = 0; m_rd = 0; m_ovr = 0;
        end else begin : mdl
            bit acc;
            bit done;
            acc  = cmd_valid && m_ready();
            done = 0;
            if (m_armed && rd_ser_valid) begin
                m_val = {m_val[14:0], rd_ser_in};
                m_nb++;
                if (m_nb == (m_full ? 16 : 8)) done = 1;
            end
            if (done) begin
                if (m_rv && !rsp_ready) m_ovr = 1;
                m_rv    = 1;
                m_rd    = m_full ? m_val : {8'h00, m_val[7:0]};
                m_armed = 0;
            end else if (m_rv && rsp_ready) begin
                m_rv = 0;
            end
            if (acc) begin
                m_frame = 1; m_pos = 0;
                m_op = cmd_op; m_bytes = cmd_bytes; m_addr = cmd_addr; m_wdata = cmd_wdata;
                if (!cmd_op && cmd_bytes != 2'b00) begin
                    m_armed = 1; m_nb = 0; m_val = 0; m_full = (cmd_bytes == 2'b11);
                end
            end else if (m_frame) begin
                if (m_pos == 22) m_frame = 0;
                else m_pos++;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [2:0] er;
        bit ea;
        bit ed;
        er = m_frame ? {m_bytes, m_op} : 3'b000;
        ea = (m_frame && m_pos >= 1 && m_pos <= 20) ? m_addr[20 - m_pos] : 1'b0;
        ed = (m_frame && m_op && m_pos >= 1 && m_pos <= 16) ? m_wdata[16 - m_pos] : 1'b0;
        chk("cmd_ready", cmd_ready, m_ready());
        chk("rw_sel", rw_sel, er);
        chk("addr_ser", addr_ser, ea);
        chk("data_ser", data_ser, ed);
        chk("frame_start", frame_start, m_frame && m_pos == 0);
        chk("busy", busy, m_frame);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_data", rsp_data, m_rd);
`ifdef BURST_SEQ_OVERRUN_EN
        chk("rsp_overrun", rsp_overrun, m_ovr);
`endif
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Offer a command until accepted; returns in the counter-0 cycle of its frame.
    task automatic send(input bit op, input bit [1:0] b, input bit [19:0] a, input bit [15:0] w);
        bit done;
        done = 0;
        cmd_valid = 1; cmd_op = op; cmd_bytes = b; cmd_addr = a; cmd_wdata = w;
        for (int i = 0; i < 200 && !done; i++) begin
            #1;
            done = cmd_ready;
            cyc();
        end
        cmd_valid = 0;
        cmd_op    = 1'($urandom);
        cmd_bytes = 2'($urandom);
        cmd_addr  = 20'($urandom);
        cmd_wdata = 16'($urandom);
        chk("send_accepted", done, 1);
    endtask

    task automatic drive_bits(input bit [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            rd_ser_valid = 1;
            rd_ser_in    = v[i];
            cyc();
        end
        rd_ser_valid = 0;
        rd_ser_in    = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) cyc();
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        bit [19:0] av;
        bit [15:0] dv;
        int rw_cnt;
        bit fs0;
        int starts[4];
        int ns;
        int rdy;

        cyc(3);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_data", rsp_data, 16'h0000);
        rst = 1;
        #1;
        chk("ready_after_release", cmd_ready, 1);
        cyc();

        // Full-word write with literal serial patterns
        send(1, 2'b11, 20'hA5A5A, 16'hC3F0);
        av = '0; dv = '0; rw_cnt = 0; fs0 = 0;
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            if (k == 0) fs0 = frame_start;
            if (k >= 1 && k <= 20) av[20 - k] = addr_ser;
            if (k >= 1 && k <= 16) dv[16 - k] = data_ser;
            if (rw_sel == 3'b111) rw_cnt++;
        end
        chk("wr_addr_bits", av, 20'hA5A5A);
        chk("wr_data_bits", dv, 16'hC3F0);
        chk("wr_rw_sel_cycles", rw_cnt, 23);
        chk("wr_frame_start", fs0, 1);
        @(negedge clk);
        chk("wr_idle_after", busy, 0);
        cyc();

        // Full-word read held until consumed
        send(0, 2'b11, 20'h12345, 16'h0000);
        drive_bits(16'h1234, 16);
        cyc(3);
        chk("rd16_valid", rsp_valid, 1);
        chk("rd16_data", rsp_data, 16'h1234);
        rsp_ready = 1; cyc(); rsp_ready = 0;
        chk("rd16_cleared", rsp_valid, 0);

        // Lower-byte read; trailing valid bits must be ignored
        send(0, 2'b01, 20'h00F00, 16'h0000);
        drive_bits(16'h00BE, 8);
        chk("rd8_valid", rsp_valid, 1);
        chk("rd8_data", rsp_data, 16'h00BE);
        drive_bits(16'hFFFF, 4);
        chk("rd8_data_held", rsp_data, 16'h00BE);
        rsp_ready = 1; cyc(); rsp_ready = 0;

        // Back-to-back writes
        cmd_valid = 1; cmd_op = 1; cmd_bytes = 2'b11; cmd_addr = 20'h0F0F0; cmd_wdata = 16'h55AA;
        ns = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (frame_start && ns < 4) begin
                starts[ns] = c;
                ns++;
            end
        end
        cyc();
        cmd_valid = 0;
        chk("b2b_frames", ns >= 3, 1);
        chk("b2b_gap1", starts[1] - starts[0], 23);
        chk("b2b_gap2", starts[2] - starts[1], 23);
        wait_idle();

        // Pending response blocks a second read but not a write
        send(0, 2'b11, 20'h00001, 16'h0000);
        drive_bits(16'hA55A, 16);
        cmd_valid = 1; cmd_op = 0; cmd_bytes = 2'b10;
        rdy = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (cmd_ready) rdy++;
            cyc();
        end
        chk("rd_blocked_ready", rdy, 0);
        chk("rd_pending_data", rsp_data, 16'hA55A);
        send(1, 2'b11, 20'h0F0F0, 16'h5A5A);
        chk("wr_during_pending_rw", rw_sel, 3'b111);
        rsp_ready = 1; cyc(); rsp_ready = 0;
        wait_idle();

        // Reset at counter 10 of a read with a partial capture
        send(0, 2'b11, 20'hFFFFF, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            rd_ser_valid = 1; rd_ser_in = 1; cyc();
        end
        rd_ser_valid = 0; rd_ser_in = 0;
        cyc(5);
        rst = 0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rw_sel", rw_sel, 3'b000);
        chk("rst_mid_ready", cmd_ready, 0);
        chk("rst_mid_frame_start", frame_start, 0);
        cyc(2);
        rst = 1;
        cyc();
        send(0, 2'b11, 20'h00002, 16'h0000);
        drive_bits(16'h0F0F, 16);
        chk("post_rst_rd_valid", rsp_valid, 1);
        chk("post_rst_rd_data", rsp_data, 16'h0F0F);
        rsp_ready = 1; cyc(); rsp_ready = 0;
        cyc(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_sequencer.md
BURST_SEQUENCER -- requirements
Module: burst_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 cmd_valid  in  1  command offered.
REQ-004 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-005 cmd_op  in  1  1 = write, 0 = read.
REQ-006 cmd_bytes  in  2  00 nop, 01 lower byte, 10 upper byte, 11 full word.
REQ-007 cmd_addr  in  20  MRAM word address.
REQ-008 cmd_wdata  in  16  write data.
REQ-009 rw_sel  out  3  {cmd_bytes, cmd_op} to the control stage; held for the whole frame.
REQ-010 addr_ser  out  1  serial address bit, MSB first.
REQ-011 data_ser  out  1  serial write data bit, MSB first.
REQ-012 frame_start  out  1  one-cycle pulse at frame cycle 0.
REQ-013 rd_ser_in  in  1  serial read data from the MRAM data-in stage, MSB first.
REQ-014 rd_ser_valid  in  1  rd_ser_in qualifier.
REQ-015 rsp_valid  out  1  read response available.
REQ-016 rsp_data  out  16  read response; half-word results zero-extended in [7:0].
REQ-017 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-018 busy  out  1  high while state is RUN.

Function
REQ-019 States: IDLE and RUN; frame counter 5 bits, counts 0..22, then wraps to 0 (23-cycle frame).
REQ-020 IDLE: rw_sel = 3'b000, cmd_ready = 1 unless blocked per REQ-027; on accept, latch command, go to RUN, counter = 0 next cycle.
REQ-021 RUN: rw_sel = latched {bytes, op}; frame_start = 1 at counter 0.
REQ-022 addr_ser = latched addr[20-k] on counter k, k = 1..20; 0 otherwise.
REQ-023 data_ser = latched wdata[16-k] on counter k, k = 1..16, writes only; 0 otherwise and for reads.
REQ-024 cmd_ready = 1 in RUN only at counter 22; an accept there starts the next frame at counter 0 with no idle cycle; no accept returns to IDLE.
REQ-025 Read with cmd_bytes != 00 arms capture: expected width is 16 for 11 and 8 otherwise. Read or write with bytes = 00 runs a full frame with no response.
REQ-026 Capture: each cycle with rd_ser_valid high while armed shifts rd_ser_in in. When the bit count reaches the expected width, load rsp_data, set rsp_valid, and disarm. rd_ser_valid while unarmed is ignored.
REQ-027 cmd_ready is forced low while armed, or while rsp_valid is high, when cmd_op = 0 and cmd_bytes != 00; writes and nops are not blocked.
REQ-028 rsp_valid clears the cycle after handshake; a capture completing in that same cycle sets it again (set wins).
REQ-029 Latched command is stable from accept until the frame ends; cmd_* changes mid-frame have no effect.

Reset
REQ-030 While rst is low: state IDLE, counter 0, capture disarmed, bit count 0, cmd_ready 0, rw_sel 0, addr_ser 0, data_ser 0, frame_start 0, rsp_valid 0, rsp_data 0, busy 0.
REQ-031 Reset mid-frame discards the frame and any partial capture. cmd_ready rises the first cycle after rst deasserts.

Configuration
REQ-032 Macro BURST_SEQ_OVERRUN_EN defined: adds output rsp_overrun (1 bit, reset 0). It is sticky, set when a capture completes while rsp_valid && !rsp_ready, and cleared only by reset. The new data overwrites rsp_data.
REQ-033 BURST_SEQ_OVERRUN_EN undefined: port absent; overwrite behaviour unchanged.

Verification
REQ-034 Write: op=1, bytes=11, addr=20'hA5A5A, wdata=16'hC3F0 -> rw_sel=3'b111 for 23 cycles; addr_ser=1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1,1,0,1,0 on counter 1..20; data_ser=1,1,0,0,0,0,1,1,1,1,1,1,0,0,0,0 on counter 1..16.
REQ-035 Read full word: op=0, bytes=11; drive 16 valid bits of 16'h1234 -> rsp_valid=1, rsp_data=16'h1234, held until rsp_ready.
REQ-036 Read lower byte: op=0, bytes=01; drive 8 bits 8'hBE -> rsp_data=16'h00BE after the 8th bit; further rd_ser_valid ignored.
REQ-037 Back-to-back writes offered continuously -> frame_start every 23 cycles, no gap; cmd_ready high only at counter 22.
REQ-038 Read pending with rsp_ready=0 and a second read offered -> cmd_ready stays 0 until the response is consumed; a write offered in the same state is accepted.
REQ-039 rst low at counter 10 of a read -> all outputs at reset values; after release, a new read captures cleanly with no stale bits.
